load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator-side memory access controller that turns load/store requests from the core pipeline into single-port accesses to the word-organised data memory. It handles byte, halfword and word accesses. Sub-word stores use read-modify-write, since the memory writes whole words only. Load data is sign- or zero-extended, and misaligned or out-of-range requests are reported as errors without touching memory. It sits between the execute/memory pipeline stage and the data memory.

## Interface
Parameters:
- MEM_BYTES, 1024, size of the addressable data memory in bytes; an address ≥ MEM_BYTES is out of range.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on a cycle where req_valid & req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed on a cycle where resp_valid & resp_ready.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, illegal size, or out-of-range request.
- mem_read  out  1  memory read enable; memory read data is combinational.
- mem_write  out  1  memory write enable; memory writes on the clk edge.
- mem_addr  out  32  word-aligned address {addr[31:2], 2'b00}.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  memory read data, valid in the same cycle as mem_read.

## Operation
- Byte ordering is little-endian: the byte lane is addr[1:0] and the halfword lane is addr[1].
- The FSM has four states: IDLE, RD, WR, RESP.
- IDLE:
  - req_ready = 1.
  - On handshake, latch we, size, unsigned, addr and wdata.
  - An error is a half access with addr[0]=1, a word access with addr[1:0]≠0, size 11, or addr ≥ MEM_BYTES. On error go to RESP with err=1.
  - Otherwise a load or a sub-word store goes to RD, and a word store goes to WR.
- RD:
  - Drive mem_read=1 and mem_addr.
  - Register mem_rdata at the clock edge.
  - A load goes to RESP with the extracted, extended data.
  - A sub-word store goes to WR with the merged word: the target lane is replaced by the store data and the other lanes are kept.
- WR:
  - Drive mem_write=1, mem_addr, and mem_wdata (merged word, or req_wdata for a word store).
  - Then go to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable.
  - Stay until resp_ready=1, then go to IDLE.
- req_ready=0 in every state other than IDLE, so only one transaction is outstanding.
- mem_read and mem_write are never asserted in the same cycle.
- mem_* outputs are decoded from registered state only; there is no combinational path from req_* to mem_*.

## Timing
- Accepting a request takes one cycle in IDLE.
- Load: accept edge, 1 cycle in RD, then resp_valid high in the next cycle. resp_valid rises 2 cycles after the accept cycle.
- Word store: accept, then 1 cycle in WR, then RESP. Memory is updated at the edge that ends WR.
- Sub-word store: accept, then RD, then WR, then RESP. resp_valid rises 3 cycles after the accept cycle.
- Error: RESP in the cycle after accept; no mem_read or mem_write is issued.
- Back-to-back: a new request can be accepted in the cycle after the resp handshake, because that cycle is IDLE.
- Reset (rst_n low, at any time):
  - State goes to IDLE.
  - All outputs read 0 while rst_n is low: req_ready, resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_addr, mem_wdata.
  - After rst_n deasserts, req_ready goes to 1.
- Reset mid-operation:
  - The transaction is aborted and no response is produced.
  - mem_write drops immediately. If reset arrives before the WR edge, memory is unchanged.

## Test plan
Memory preload: word 0x10 = 0x8899AABB.
- LW 0x10 → resp_rdata=0x8899AABB and err=0; one mem_read cycle with mem_addr=0x10; resp_valid high 2 cycles after accept.
- LB 0x13 → 0xFFFFFF88; LBU 0x13 → 0x00000088; LH 0x10 → 0xFFFFAABB; LHU 0x12 → 0x00008899.
- SB 0x11 with wdata 0x000000CC → one RD cycle then one WR cycle with mem_wdata=0x8899CCBB and mem_addr=0x10. SH 0x12 with wdata 0x00001234 → mem_wdata=0x1234CCBB. A following LW 0x10 returns 0x1234CCBB.
- SW 0x0E → err=1, rdata=0, no mem_read/mem_write. LH 0x11 → err=1. LW 0x400 (MEM_BYTES=1024) → err=1. req_size=11 → err=1.
- resp_ready held low for 5 cycles during an LW → resp_valid, rdata and err stay stable, req_ready=0, and a second req_valid is not accepted until the cycle after the resp handshake.
- rst_n pulsed low during the RD cycle of SB 0x10 → mem_write is never asserted, word 0x10 is unchanged, all outputs are 0 during reset, and req_ready=1 afterwards.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns core load/store requests into single-port word accesses,
// doing read-modify-write for sub-word stores and sign/zero extension for loads.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam logic [1:0]  SZ_B = 2'b00;
  localparam logic [1:0]  SZ_H = 2'b01;
  localparam logic [1:0]  SZ_W = 2'b10;
  localparam logic [1:0]  SZ_X = 2'b11;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t          state;
  state_t          next_state;

  logic            we_q;
  logic            uns_q;
  logic [1:0]      size_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;

  logic            accept;
  logic            req_bad;
  logic [AW-1:0]   mem_addr_nxt;
  logic [DW-1:0]   mem_wdata_nxt;
  logic [DW-1:0]   resp_rdata_nxt;
  logic            resp_err_nxt;

  // Pick the addressed lane out of a memory word and extend it to 32 bits.
  function automatic logic [DW-1:0] extend_load(input logic [DW-1:0] word,
                                                 input logic [1:0]    lane,
                                                 input logic [1:0]    size,
                                                 input logic          uns);
    logic [DW-1:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      SZ_B:    extend_load = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    extend_load = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: extend_load = word;
    endcase
  endfunction

  // Replace the target lane of a memory word with right-aligned store data.
  function automatic logic [DW-1:0] merge_word(input logic [DW-1:0] word,
                                                input logic [1:0]    lane,
                                                input logic [1:0]    size,
                                                input logic [DW-1:0] data);
    logic [DW-1:0] mask;
    mask = (size == SZ_B) ? 32'h0000_00FF : 32'h0000_FFFF;
    merge_word = (word & ~(mask << {lane, 3'b000})) | ((data & mask) << {lane, 3'b000});
  endfunction

  assign accept = req_valid & req_ready;

  // Misaligned, illegal-size and out-of-range requests never reach memory.
  always_comb begin
    req_bad = 1'b0;
    if (req_addr >= AW'(MEM_BYTES))                  req_bad = 1'b1;
    if (req_size == SZ_X)                            req_bad = 1'b1;
    if ((req_size == SZ_H) && req_addr[0])           req_bad = 1'b1;
    if ((req_size == SZ_W) && (req_addr[1:0] != 2'b00)) req_bad = 1'b1;
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    next_state     = state;
    mem_wdata_nxt  = '0;
    mem_addr_nxt   = '0;
    resp_rdata_nxt = resp_rdata;
    resp_err_nxt   = resp_err;
    unique case (state)
      IDLE: begin
        if (accept) begin
          resp_rdata_nxt = '0;
          resp_err_nxt   = 1'b0;
          if (req_bad) begin
            next_state   = RESP;
            resp_err_nxt = 1'b1;
          end else if (req_we && (req_size == SZ_W)) begin
            next_state    = WR;
            mem_wdata_nxt = req_wdata;
          end else begin
            next_state = RD;
          end
        end
      end
      RD: begin
        if (we_q) begin
          next_state    = WR;
          mem_wdata_nxt = merge_word(mem_rdata, addr_q[1:0], size_q, wdata_q);
        end else begin
          next_state     = RESP;
          resp_rdata_nxt = extend_load(mem_rdata, addr_q[1:0], size_q, uns_q);
          resp_err_nxt   = 1'b0;
        end
      end
      WR: begin
        next_state = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          next_state     = IDLE;
          resp_rdata_nxt = '0;
          resp_err_nxt   = 1'b0;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    if ((next_state == RD) || (next_state == WR)) begin
      mem_addr_nxt = (state == IDLE) ? {req_addr[AW-1:2], 2'b00} : {addr_q[AW-1:2], 2'b00};
    end
  end

  // State and registered outputs; mem_* depend only on these flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= next_state;
      req_ready  <= (next_state == IDLE);
      resp_valid <= (next_state == RESP);
      resp_rdata <= resp_rdata_nxt;
      resp_err   <= resp_err_nxt;
      mem_read   <= (next_state == RD);
      mem_write  <= (next_state == WR);
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
    end
  end

  // Request fields captured at the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      uns_q   <= req_unsigned;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed test-plan steps, reset abort,
// then random traffic checked against a byte-array reference memory.
module tb_load_store_unit;

  localparam int unsigned MEM_BYTES = 1024;
  localparam int unsigned WORDS     = MEM_BYTES / 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem     [WORDS];
  logic [31:0] pre     [WORDS];
  logic [7:0]  ref_mem [MEM_BYTES];
  logic        preload;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_mem_wr = 0;

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory: combinational read, write on the clock edge.
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < int'(WORDS); i++) mem[i] <= pre[i];
    end else if (mem_write) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      n_mem_wr++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = ref_mem[(a & ~3) + i];
    return v;
  endfunction

  function automatic logic [31:0] ref_load(input int a, input int nb, input logic uns);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[a + i];
    if (!uns && nb < 4 && v[8*nb-1])
      for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // One complete transaction; checks timing, memory traffic and response.
  task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int stall, output logic [31:0] got);
    int nb, rd, wr, lat, w, exp_lat, exp_rd, exp_wr;
    logic exp_err, done;
    logic [31:0] exp_rdata, exp_word, hold_rdata;
    logic hold_err;
    nb      = (size == 2'b11) ? 1 : (1 << size);
    exp_err = (size == 2'b11) || (addr % nb != 0) || (addr >= MEM_BYTES);
    exp_rdata = '0;
    exp_word  = '0;
    if (!exp_err && !we) exp_rdata = ref_load(int'(addr), nb, uns);
    if (!exp_err && we) begin
      for (int i = 0; i < nb; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
      exp_word = ref_word(int'(addr));
    end
    if (exp_err)      begin exp_lat = 1; exp_rd = 0; exp_wr = 0; end
    else if (!we)     begin exp_lat = 2; exp_rd = 1; exp_wr = 0; end
    else if (nb == 4) begin exp_lat = 2; exp_rd = 0; exp_wr = 1; end
    else              begin exp_lat = 3; exp_rd = 1; exp_wr = 1; end

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    w = 0;
    while (!req_ready && w < 10) begin @(negedge clk); w++; end
    chk("accept_wait", 32'(w), 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;

    rd = 0; wr = 0; lat = 0; done = 1'b0;
    while (!done && lat < 8) begin
      @(negedge clk);
      lat++;
      if (resp_valid) done = 1'b1;
      else begin
        if (mem_read && mem_write) chk("rd_wr_excl", 32'(mem_read & mem_write), 32'd0);
        if (mem_read) begin
          rd++;
          chk("rd_addr", mem_addr, addr & ~32'd3);
        end
        if (mem_write) begin
          wr++;
          chk("wr_addr", mem_addr, addr & ~32'd3);
          chk("wr_data", mem_wdata, exp_word);
        end
      end
    end
    chk("resp_latency", 32'(lat), 32'(exp_lat));
    chk("mem_reads", 32'(rd), 32'(exp_rd));
    chk("mem_writes", 32'(wr), 32'(exp_wr));
    chk("resp_rdata", resp_rdata, exp_rdata);
    chk("resp_err", 32'(resp_err), 32'(exp_err));
    got = resp_rdata;
    hold_rdata = resp_rdata;
    hold_err   = resp_err;

    // Held-off response: outputs stable, no new request taken.
    for (int s = 0; s < stall; s++) begin
      req_valid = 1'b1;
      @(negedge clk);
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_rdata", resp_rdata, hold_rdata);
      chk("stall_err", 32'(resp_err), 32'(hold_err));
      chk("stall_ready", 32'(req_ready), 32'd0);
      chk("stall_nomem", 32'(mem_read | mem_write), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] got;
    logic [1:0]  sz;
    logic [31:0] a;
    int          r;
    rst_n = 1'b0; preload = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    for (int i = 0; i < int'(WORDS); i++) begin
      pre[i] = (i == 4) ? 32'h8899_AABB : $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = pre[i][8*b +: 8];
    end

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    preload = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // Directed test-plan loads and stores
    txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, got); chk("LW_10", got, 32'h8899_AABB);
    txn(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0, got); chk("LB_13", got, 32'hFFFF_FF88);
    txn(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0, got); chk("LBU_13", got, 32'h0000_0088);
    txn(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 0, got); chk("LH_10", got, 32'hFFFF_AABB);
    txn(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 0, got); chk("LHU_12", got, 32'h0000_8899);
    txn(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00CC, 0, got);
    chk("SB_11_mem", mem[4], 32'h8899_CCBB);
    txn(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_1234, 0, got);
    chk("SH_12_mem", mem[4], 32'h1234_CCBB);
    txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, got); chk("LW_10_after", got, 32'h1234_CCBB);

    // Error cases
    txn(1'b1, 2'b10, 1'b0, 32'h0E, 32'hDEAD_BEEF, 0, got); chk("SW_0E_rdata", got, 32'h0);
    txn(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 0, got);
    txn(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 0, got);
    txn(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0, got);

    // Held-off response
    txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5, got); chk("LW_stall", got, 32'h1234_CCBB);

    // Reset during the RD cycle of SB 0x10
    begin
      int wr_before;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h10; req_wdata = 32'h0000_0055;
      @(posedge clk);
      #1 req_valid = 1'b0;
      wr_before = n_mem_wr;
      @(negedge clk);
      chk("abort_in_rd", 32'(mem_read), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_req_ready", 32'(req_ready), 32'd0);
      chk("abort_resp_valid", 32'(resp_valid), 32'd0);
      chk("abort_resp_rdata", resp_rdata, 32'd0);
      chk("abort_resp_err", 32'(resp_err), 32'd0);
      chk("abort_mem_read", 32'(mem_read), 32'd0);
      chk("abort_mem_write", 32'(mem_write), 32'd0);
      chk("abort_mem_addr", mem_addr, 32'd0);
      chk("abort_mem_wdata", mem_wdata, 32'd0);
      repeat (2) @(negedge clk);
      chk("abort_hold_write", 32'(mem_write), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_ready_after", 32'(req_ready), 32'd1);
      chk("abort_resp_after", 32'(resp_valid), 32'd0);
      chk("abort_no_writes", 32'(n_mem_wr), 32'(wr_before));
      chk("abort_word_kept", mem[4], ref_word(32'h10));
    end

    // Random traffic against the reference memory
    for (int t = 0; t < 80; t++) begin
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      r  = int'($urandom_range(0, 9));
      if (r == 0) a = 32'(MEM_BYTES) + $urandom_range(0, 4095);
      else begin
        a = 32'($urandom_range(0, MEM_BYTES - 1));
        if (r < 8 && sz != 2'b11) a = a & ~((32'd1 << sz) - 32'd1);
      end
      txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
          int'($urandom_range(0, 2)), got);
    end

    // Final memory image
    @(negedge clk);
    for (int i = 0; i < int'(WORDS); i++) chk("final_mem", mem[i], ref_word(4*i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
